// File: rtl/tick_divider_chain.sv
// Prescaler plus a cascade of equal modulo stages; emits per-stage clock-enable ticks,
// square waves, and one runtime-selected tick/square pair, all in the CLK domain.
module tick_divider_chain #(
  parameter int unsigned PRESCALE  = 50,
  parameter int unsigned STAGE_DIV = 10,
  parameter int unsigned STAGES    = 7,
  parameter int unsigned SELW      = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              CLR,
  input  logic [SELW-1:0]   SEL,
  output logic [STAGES-1:0] tick,
  output logic [STAGES-1:0] sq,
  output logic              tick_sel,
  output logic              sq_sel
);

  localparam int unsigned W0 = $clog2(PRESCALE);
  localparam int unsigned WK = $clog2(STAGE_DIV);

  localparam logic [W0-1:0] Max0  = W0'(PRESCALE - 1);
  localparam logic [W0-1:0] Half0 = W0'(PRESCALE / 2);
  localparam logic [WK-1:0] MaxK  = WK'(STAGE_DIV - 1);
  localparam logic [WK-1:0] HalfK = WK'(STAGE_DIV / 2);

  logic              clear;
  logic [STAGES-1:0] tc;      // stage counter at terminal value
  logic [STAGES-1:0] wrap;
  logic [STAGES-1:0] sq_d;
  logic [STAGES-1:0] tick_q;
  logic [STAGES-1:0] sq_q;
  logic              tick_sel_d, tick_sel_q;
  logic              sq_sel_d, sq_sel_q;
  logic [W0-1:0]     cnt0_q, cnt0_d;

  assign clear = RST | CLR;

  // Wrap of stage k needs every lower stage at terminal count in the same cycle.
  for (genvar k = 0; k < STAGES; k++) begin : g_wrap
    assign wrap[k] = EN & (&tc[k:0]);
  end

  assign tc[0] = (cnt0_q == Max0);

  always_comb begin
    cnt0_d = cnt0_q;
    if (wrap[0]) begin
      cnt0_d = '0;
    end else if (EN) begin
      cnt0_d = cnt0_q + W0'(1);
    end
  end

  assign sq_d[0] = (cnt0_d >= Half0);

  always_ff @(posedge CLK) begin
    if (clear) begin
      cnt0_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
    end
  end

  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    logic [WK-1:0] cnt_q, cnt_d;

    assign tc[k] = (cnt_q == MaxK);

    always_comb begin
      cnt_d = cnt_q;
      if (wrap[k]) begin
        cnt_d = '0;
      end else if (wrap[k-1]) begin
        cnt_d = cnt_q + WK'(1);
      end
    end

    assign sq_d[k] = (cnt_d >= HalfK);

    always_ff @(posedge CLK) begin
      if (clear) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  // Select from next-state values so the selected outputs line up with tick/sq.
  always_comb begin
    tick_sel_d = 1'b0;
    sq_sel_d   = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (SEL == SELW'(k)) begin
        tick_sel_d = wrap[k];
        sq_sel_d   = sq_d[k];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      tick_q     <= '0;
      sq_q       <= '0;
      tick_sel_q <= 1'b0;
      sq_sel_q   <= 1'b0;
    end else begin
      tick_q     <= wrap;
      sq_q       <= sq_d;
      tick_sel_q <= tick_sel_d;
      sq_sel_q   <= sq_sel_d;
    end
  end

  assign tick     = tick_q;
  assign sq       = sq_q;
  assign tick_sel = tick_sel_q;
  assign sq_sel   = sq_sel_q;

endmodule
